// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encodings and the default operand width.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder cell; the only arithmetic element of the
// serial adder datapath.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one bit per clock, LSB first,
// result shifted into sum from the MSB side.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_co;

  serial_fa_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ADD: begin
        sum_d = {fa_s, sum_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_co;
        if (cnt_q == LAST) begin
          // c_q here is the carry into the MSB
          cout_d  = fa_co;
          ovf_d   = c_q ^ fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ADD) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed table, random
// operations against an arithmetic model, and reset/restart sequences.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int nchk;
  int nerr;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         ci;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic s, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic ci,
                       output logic [W-1:0] rs, output logic rc,
                       output logic ro);
    logic [W:0]   t;
    logic [W-1:0] bx;
    bx = s ? ~vb : vb;
    t  = {1'b0, va} + {1'b0, bx} + (s ? (W+1)'(1) : (W+1)'(ci));
    rs = t[W-1:0];
    rc = t[W];
    ro = (va[W-1] == bx[W-1]) && (rs[W-1] != va[W-1]);
  endtask

  task automatic scramble();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Entered #1 after a posedge with the DUT idle; leaves it idle.
  task automatic run_op(input string nm, input logic s,
                        input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic ci, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int bad;
    bad   = 0;
    sub   = s;
    a     = va;
    b     = vb;
    cin   = ci;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    if (busy !== 1'b1 || done !== 1'b0) bad++;
    for (int i = 1; i <= W + 1; i++) begin
      @(posedge clk); #1;
      if (done !== (i == W)) bad++;
      if (busy !== (i <= W)) bad++;
      if (i == W && sum !== es) bad++;
      scramble();
    end
    check({nm, "_timing"}, 32'(bad), 32'd0);
    check({nm, "_sum"}, 32'(sum), 32'(es));
    check({nm, "_cout"}, 32'(cout), 32'(ec));
    check({nm, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  vec_t tbl[7];

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    logic         ro;
    int           dn;
    int           bad;
    nchk = 0;
    nerr = 0;

    tbl[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].va, tbl[i].vb,
             tbl[i].ci, tbl[i].es, tbl[i].ec, tbl[i].eo);

    for (int i = 0; i < 24; i++) begin
      logic         s;
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         ci;
      s  = 1'($urandom);
      va = W'($urandom);
      vb = W'($urandom);
      ci = 1'($urandom);
      model(s, va, vb, ci, rs, rc, ro);
      run_op($sformatf("rnd%0d", i), s, va, vb, ci, rs, rc, ro);
    end

    // Reset during the 4th ADD cycle, with start also asserted.
    sub   = 1'b0;
    a     = 8'hFF;
    b     = 8'h00;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    check("rst_prio_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    bad   = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort_no_done", 32'(bad), 32'd0);

    // Start held high with new operands through ADD and DONE.
    sub   = 1'b0;
    a     = 8'h3C;
    b     = 8'h21;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    sub = 1'b1;
    a   = 8'hAA;
    b   = 8'h55;
    cin = 1'b1;
    dn  = 0;
    for (int i = 1; i <= W + 1; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    check("hold_sum", 32'(sum), 32'h5D);
    check("hold_cout", 32'(cout), 32'd0);
    check("hold_ovf", 32'(ovf), 32'd0);
    check("hold_ndone", 32'(dn), 32'd1);
    check("hold_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    dn    = 0;
    for (int i = 0; i < W + 2 && dn == 0; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn = 1;
    end
    check("restart_done", 32'(dn), 32'd1);
    check("restart_sum", 32'(sum), 32'h55);
    check("restart_cout", 32'(cout), 32'd1);
    check("restart_ovf", 32'(ovf), 32'd1);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
